// File: rtl/hazard_sb.sv
// hazard_sb: hazard unit for the dual-ISA (ARM/RISC-V) 5-stage pipeline.
//   Forwards from M and W, detects load-use hazards while ignoring x0,
//   and keeps a one-entry scoreboard for a multi-cycle MDU op with
//   programmable latency. It stalls on RAW, WAW and structural hazards
//   against that op. A taken redirect takes priority over any stall, and
//   ARM PC writes flush the pipeline.
// Optional feature macro: HAZARD_PERF_EN adds the saturating stall and
//   flush cycle counters.
// Ports:
//   clk, rst_n                  clock; asynchronous active-low reset
//   armD/E/M/W                  stage holds an ARM instruction (0 = RISC-V)
//   Rs1D, Rs2D, RdD, RegWriteD  D-stage sources, destination, write enable
//   MdOpD                       D-stage instruction is an MDU op
//   Rs1E, Rs2E, RdE, LoadE      E-stage sources, destination, load flag
//   RdM/RdW, RegWriteM/W        M/W destinations and write enables
//   MdStartE, MdLatE            MDU issue from E and its latency
//   PCSrcD/E/M/W, BranchTakenE  ARM PC-write and taken-branch flags
//   RVPCSrcE                    RISC-V branch/jump taken in E
//   StallF, StallD              hold the F / D pipeline registers
//   FlushD, FlushE              clear the D / E pipeline registers
//   ForwardAE, ForwardBE        00 regfile, 01 ResultW, 10 ALUOutM
//   MdBusy                      scoreboard entry valid
//   StallCycles, FlushCycles    perf counters (HAZARD_PERF_EN only)
module hazard_sb #(
  parameter int unsigned REGW = 5,
  parameter int unsigned LATW = 4,
  parameter int unsigned CNTW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            armD,
  input  logic            armE,
  input  logic            armM,
  input  logic            armW,
  input  logic [REGW-1:0] Rs1D,
  input  logic [REGW-1:0] Rs2D,
  input  logic [REGW-1:0] RdD,
  input  logic            RegWriteD,
  input  logic            MdOpD,
  input  logic [REGW-1:0] Rs1E,
  input  logic [REGW-1:0] Rs2E,
  input  logic [REGW-1:0] RdE,
  input  logic            LoadE,
  input  logic [REGW-1:0] RdM,
  input  logic [REGW-1:0] RdW,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  input  logic            MdStartE,
  input  logic [LATW-1:0] MdLatE,
  input  logic            PCSrcD,
  input  logic            PCSrcE,
  input  logic            PCSrcM,
  input  logic            PCSrcW,
  input  logic            BranchTakenE,
  input  logic            RVPCSrcE,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic            FlushE,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
`ifdef HAZARD_PERF_EN
  output logic [CNTW-1:0] StallCycles,
  output logic [CNTW-1:0] FlushCycles,
`endif
  output logic            MdBusy
);

  // RISC-V x0 is hardwired to zero, so it never creates a dependency.
  // ARM r0 is a real register and must still be compared.
  function automatic logic is_zero(input logic [REGW-1:0] r, input logic arm);
    return ~arm & (r == '0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (!is_zero(rs, armE)) begin
      if (RegWriteM && (RdM == rs))      sel = 2'b10;
      else if (RegWriteW && (RdW == rs)) sel = 2'b01;
    end
    return sel;
  endfunction

  logic            md_busy_q, md_busy_d;
  logic [LATW-1:0] md_cnt_q,  md_cnt_d;
  logic [REGW-1:0] md_rd_q,   md_rd_d;

  logic ld_stall, md_stall, redirect, pc_wr_pend_f, h_stall;
  logic md_accept, md_last, md_raw, md_waw, md_struct;

  always_comb begin
    ForwardAE = fwd_sel(Rs1E);
    ForwardBE = fwd_sel(Rs2E);
  end

  // A load whose destination is x0 produces nothing to wait for.
  always_comb begin
    ld_stall = LoadE & ~is_zero(RdE, armE) &
               (((Rs1D == RdE) & ~is_zero(Rs1D, armD)) |
                ((Rs2D == RdE) & ~is_zero(Rs2D, armD)));
  end

  assign md_last   = (md_cnt_q == LATW'(1));
  assign md_accept = MdStartE & (MdLatE != '0) & (~md_busy_q | md_last);

  always_comb begin
    md_raw    = ((Rs1D == md_rd_q) & ~is_zero(Rs1D, armD)) |
                ((Rs2D == md_rd_q) & ~is_zero(Rs2D, armD));
    md_waw    = RegWriteD & (RdD == md_rd_q);
    md_struct = MdOpD & (md_cnt_q > LATW'(1));
    md_stall  = md_busy_q & (md_raw | md_waw | md_struct);
  end

  always_comb begin
    redirect     = (armE & BranchTakenE) | (~armE & RVPCSrcE);
    pc_wr_pend_f = (armD & PCSrcD) | (armE & PCSrcE) | (armM & PCSrcM);
    // A D instruction on the wrong path is flushed, so it must not be held.
    h_stall      = (ld_stall | md_stall) & ~redirect;
    StallD       = h_stall;
    StallF       = h_stall | pc_wr_pend_f;
    FlushE       = h_stall | redirect;
    FlushD       = pc_wr_pend_f | (armW & PCSrcW) | redirect;
  end

  // Scoreboard update. A new issue is accepted only when the entry is free
  // or in its final cycle. An issue while the entry is still busy is ignored.
  // A redirect leaves the entry alone because the MDU op is older.
  always_comb begin
    md_busy_d = md_busy_q;
    md_cnt_d  = md_cnt_q;
    md_rd_d   = md_rd_q;
    if (md_accept) begin
      md_busy_d = 1'b1;
      md_cnt_d  = MdLatE;
      md_rd_d   = RdE;
    end else if (md_busy_q) begin
      if (md_cnt_q != '0) md_cnt_d = md_cnt_q - LATW'(1);
      if (md_last)        md_busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_busy_q <= 1'b0;
      md_cnt_q  <= '0;
      md_rd_q   <= '0;
    end else begin
      md_busy_q <= md_busy_d;
      md_cnt_q  <= md_cnt_d;
      md_rd_q   <= md_rd_d;
    end
  end

  assign MdBusy = md_busy_q;

`ifdef HAZARD_PERF_EN
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNTW-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallD && (stall_cnt_q != '1))            stall_cnt_d = stall_cnt_q + CNTW'(1);
    if ((FlushD || FlushE) && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCycles = stall_cnt_q;
  assign FlushCycles = flush_cnt_q;
`else
  logic unused_cntw;
  assign unused_cntw = (CNTW == 0);
`endif

endmodule

// File: tb/tb_hazard_sb.sv
module tb_hazard_sb;
  localparam int unsigned REGW = 5;
  localparam int unsigned LATW = 4;
  localparam int unsigned CNTW = 4;

  logic clk, rst_n;
  logic armD, armE, armM, armW;
  logic [REGW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteD, MdOpD, LoadE, RegWriteM, RegWriteW, MdStartE;
  logic [LATW-1:0] MdLatE;
  logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, RVPCSrcE;
  logic StallF, StallD, FlushD, FlushE, MdBusy;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
  logic [CNTW-1:0] StallCycles, FlushCycles;
`endif

  int vectors = 0;
  int miscompares = 0;

  hazard_sb #(
    .REGW(REGW),
    .LATW(LATW),
    .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .armD(armD), .armE(armE), .armM(armM), .armW(armW),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD), .MdOpD(MdOpD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .LoadE(LoadE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MdStartE(MdStartE), .MdLatE(MdLatE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .RVPCSrcE(RVPCSrcE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
`ifdef HAZARD_PERF_EN
    .StallCycles(StallCycles), .FlushCycles(FlushCycles),
`endif
    .MdBusy(MdBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Checks the four control outputs together against {StallF,StallD,FlushD,FlushE}.
  task automatic chkctl(input string tag, input logic [3:0] exp);
    vectors++;
    assert ({StallF, StallD, FlushD, FlushE} === exp) else begin
      miscompares++;
      $error("FAIL %s: observed SF/SD/FD/FE=%b expected %b", tag,
             {StallF, StallD, FlushD, FlushE}, exp);
    end
  endtask

  task automatic clr();
    {armD, armE, armM, armW} = '0;
    {Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteD, MdOpD, LoadE, RegWriteM, RegWriteW, MdStartE} = '0;
    MdLatE = '0;
    {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, RVPCSrcE} = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    #2;
    chk1("rst_busy", MdBusy, 1'b0);
    chkctl("rst_ctl", 4'b0000);
    chk2("rst_fa", ForwardAE, 2'b00);
    tick();
    rst_n = 1'b1;
    #1;
    chk1("post_rst_busy", MdBusy, 1'b0);

    // Load-use hazard, then the same pattern on x0
    LoadE = 1'b1; RdE = 5'd5; Rs1D = 5'd5; #1;
    chkctl("lduse_rs1", 4'b1101);
    Rs1D = 5'd0; Rs2D = 5'd5; #1;
    chkctl("lduse_rs2", 4'b1101);
    Rs2D = 5'd0; RdE = 5'd0; Rs1D = 5'd0; #1;
    chkctl("lduse_x0", 4'b0000);
    armD = 1'b1; armE = 1'b1; #1;
    chkctl("lduse_arm_r0", 4'b1101);
    clr(); #1;

    // Forwarding
    RegWriteM = 1'b1; RegWriteW = 1'b1; RdM = 5'd7; RdW = 5'd7; Rs1E = 5'd7; Rs2E = 5'd7; #1;
    chk2("fwd_a_m", ForwardAE, 2'b10);
    chk2("fwd_b_m", ForwardBE, 2'b10);
    RegWriteM = 1'b0; #1;
    chk2("fwd_a_w", ForwardAE, 2'b01);
    RegWriteW = 1'b0; #1;
    chk2("fwd_a_none", ForwardAE, 2'b00);
    RegWriteM = 1'b1; RegWriteW = 1'b1; RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; #1;
    chk2("fwd_x0_rv", ForwardAE, 2'b00);
    armE = 1'b1; #1;
    chk2("fwd_r0_arm", ForwardAE, 2'b10);
    clr(); #1;

    // ARM PC-write control and redirects
    armD = 1'b1; PCSrcD = 1'b1; #1;
    chkctl("pcwr_d", 4'b1010);
    clr(); armW = 1'b1; PCSrcW = 1'b1; #1;
    chkctl("pcwr_w", 4'b0010);
    clr(); armE = 1'b1; BranchTakenE = 1'b1; #1;
    chkctl("arm_br", 4'b0011);
    clr(); RVPCSrcE = 1'b1; armE = 1'b1; #1;
    chkctl("rv_br_while_arm", 4'b0000);
    clr(); #1;

    // MDU RAW: busy for exactly four cycles
    MdStartE = 1'b1; RdE = 5'd9; MdLatE = 4'd4; #1;
    chk1("md_issue_busy0", MdBusy, 1'b0);
    tick();
    MdStartE = 1'b0; RdE = 5'd0; MdLatE = 4'd0; Rs2D = 5'd9;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("md_raw_busy", MdBusy, 1'b1);
      chk1("md_raw_stall", StallD, 1'b1);
      tick();
    end
    chk1("md_raw_busy_end", MdBusy, 1'b0);
    chk1("md_raw_stall_end", StallD, 1'b0);
    clr(); #1;

    // MDU WAW
    MdStartE = 1'b1; RdE = 5'd9; MdLatE = 4'd4;
    tick();
    clr(); RegWriteD = 1'b1; RdD = 5'd9;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("md_waw_stall", StallD, 1'b1);
      tick();
    end
    chk1("md_waw_busy_end", MdBusy, 1'b0);
    chk1("md_waw_stall_end", StallD, 1'b0);
    clr(); #1;

    // Redirect over an MDU stall, an ignored issue, structural stall, back-to-back issue
    MdStartE = 1'b1; RdE = 5'd9; MdLatE = 4'd4;
    tick();                                   // count = 4
    clr(); Rs1D = 5'd9; RVPCSrcE = 1'b1; #1;
    chkctl("redir_over_md", 4'b0011);
    chk1("redir_busy", MdBusy, 1'b1);
    tick();                                   // count = 3
    clr(); MdStartE = 1'b1; MdLatE = 4'd7; RdE = 5'd3; #1;
    chk1("redir_keeps_busy", MdBusy, 1'b1);
    chk1("no_hazard_stall", StallD, 1'b0);
    tick();                                   // count = 2 if the issue was ignored
    clr(); MdOpD = 1'b1; #1;
    chk1("md_struct_cnt2", StallD, 1'b1);
    tick();                                   // count = 1
    #1;
    chk1("md_struct_cnt1", StallD, 1'b0);
    chk1("md_busy_cnt1", MdBusy, 1'b1);
    clr(); MdStartE = 1'b1; MdLatE = 4'd2; RdE = 5'd4;
    tick();                                   // new op accepted, count = 2
    clr(); Rs1D = 5'd4; #1;
    chk1("b2b_busy", MdBusy, 1'b1);
    chk1("b2b_raw_stall", StallD, 1'b1);
    tick();
    #1;
    chk1("b2b_busy_last", MdBusy, 1'b1);
    tick();
    chk1("b2b_busy_end", MdBusy, 1'b0);
    clr(); #1;

    // Asynchronous reset in the middle of an MDU op
    MdStartE = 1'b1; RdE = 5'd9; MdLatE = 4'd4;
    tick();
    clr();
    tick();                                   // count = 3
    #2;
    rst_n = 1'b0; #1;
    chk1("async_rst_busy", MdBusy, 1'b0);
    #1;
    rst_n = 1'b1; Rs2D = 5'd9; #1;
    chk1("post_rst_stall", StallD, 1'b0);
    tick();
    chk1("post_rst_busy2", MdBusy, 1'b0);
    chk1("post_rst_stall2", StallD, 1'b0);
    clr(); #1;

`ifdef HAZARD_PERF_EN
    // Both counters saturate at 15 after 20 stalled and flushed cycles
    LoadE = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
    for (int i = 0; i < 20; i++) tick();
    vectors++;
    assert (StallCycles === 4'd15) else begin
      miscompares++;
      $error("FAIL perf_stall: observed %0d expected 15", StallCycles);
    end
    vectors++;
    assert (FlushCycles === 4'd15) else begin
      miscompares++;
      $error("FAIL perf_flush: observed %0d expected 15", FlushCycles);
    end
    clr(); #1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
